// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller: opcodes, ALU op codes, FSM states.
// The ALU op encodings here are also consumed by the datapath ALU.
package ctrl_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LW, C_SW, C_BR, C_ILL
  } iclass_t;

  // Only the instruction fields the controller actually consumes are latched.
  typedef struct packed {
    logic       bit30;
    logic [2:0] funct3;
    logic [6:0] opcode;
  } ir_t;

  function automatic iclass_t classify(input logic [6:0] op);
    case (op)
      OP_R:    return C_R;
      OP_I:    return C_I;
      OP_LW:   return C_LW;
      OP_SW:   return C_SW;
      OP_BR:   return C_BR;
      default: return C_ILL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decode.sv
// Combinational ALU operation decode from instruction class, funct3 and ir[30].
// ir[30] picks SUB/SRA for R-type; for I-type it only affects SRAI.
module alu_decode
  import ctrl_pkg::*;
(
  input  iclass_t    i_cls,
  input  logic [2:0] i_funct3,
  input  logic       i_bit30,
  output logic [3:0] o_alu_ctrl
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_cls)
      C_R, C_I: begin
        case (i_funct3)
          3'b000:  o_alu_ctrl = (i_cls == C_R && i_bit30) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_ctrl = ALU_SLL;
          3'b010:  o_alu_ctrl = ALU_SLT;
          3'b011:  o_alu_ctrl = ALU_SLT;
          3'b100:  o_alu_ctrl = ALU_XOR;
          3'b101:  o_alu_ctrl = i_bit30 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_ctrl = ALU_OR;
          default: o_alu_ctrl = ALU_AND;
        endcase
      end
      C_BR:    o_alu_ctrl = ALU_SUB;
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM (IF/ID/EX/MEM/WB) with retired-instruction counter.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt the FSM and raise 'illegal'.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32,
  parameter int WAIT_ACK = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr,
  input  logic                Zero,
  input  logic                dAck,
  output logic                loadPC,
  output logic                PCSrc,
  output logic                ALUSrc,
  output logic                RegWrite,
  output logic                MemToReg,
  output logic [3:0]          ALUCtrl,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [2:0]          state_o,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic                illegal,
`endif
  output logic [RETIRE_W-1:0] retired
);

  state_t              r_state;
  state_t              w_next;
  ir_t                 r_ir;
  logic [RETIRE_W-1:0] r_retired;
  iclass_t             w_cls;
  logic [3:0]          w_alu;
  logic                w_imm_op;
  logic                w_ack;

  assign w_cls    = classify(r_ir.opcode);
  assign w_imm_op = (w_cls == C_I) || (w_cls == C_LW) || (w_cls == C_SW);
  assign w_ack    = (WAIT_ACK != 0) ? dAck : 1'b1;

  alu_decode u_alu_decode (
    .i_cls      (w_cls),
    .i_funct3   (r_ir.funct3),
    .i_bit30    (r_ir.bit30),
    .o_alu_ctrl (w_alu)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IF;
      r_ir      <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IF)
        r_ir <= '{bit30: instr[30], funct3: instr[14:12], opcode: instr[6:0]};
      if (loadPC)
        r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  always_comb begin
    w_next   = r_state;
    loadPC   = 1'b0;
    PCSrc    = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    ALUCtrl  = ALU_ADD;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    case (r_state)
      S_IF: w_next = S_ID;
      S_ID: begin
        w_next = S_EX;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (w_cls == C_ILL) w_next = S_HALT;
`endif
      end
      S_EX: begin
        ALUSrc  = w_imm_op;
        ALUCtrl = w_alu;
        case (w_cls)
          C_LW, C_SW: w_next = S_MEM;
          C_BR: begin
            loadPC = 1'b1;
            case (r_ir.funct3)
              3'b000:  PCSrc = Zero;
              3'b001:  PCSrc = !Zero;
              default: PCSrc = 1'b0;
            endcase
            w_next = S_IF;
          end
          default: w_next = S_WB;
        endcase
      end
      S_MEM: begin
        ALUSrc   = 1'b1;
        ALUCtrl  = w_alu;
        MemRead  = (w_cls == C_LW);
        MemWrite = (w_cls == C_SW);
        // Request stays asserted unchanged until the memory acknowledges.
        if (w_ack) begin
          if (w_cls == C_SW) begin
            loadPC = 1'b1;
            w_next = S_IF;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        ALUSrc   = w_imm_op;
        ALUCtrl  = w_alu;
        RegWrite = (w_cls != C_ILL);
        MemToReg = (w_cls == C_LW);
        loadPC   = 1'b1;
        w_next   = S_IF;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  assign state_o = r_state;
  assign retired = r_retired;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = (r_state == S_HALT);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: reset, R/I/branch/load/store sequencing, mid-instruction reset, illegal opcode.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        Zero = 1'b0;
  logic        dAck = 1'b0;
  logic        loadPC, PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite;
  logic [3:0]  ALUCtrl;
  logic [2:0]  state_o;
  logic [31:0] retired;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
`endif
  logic [6:0]  strb;

  int n_checks = 0;
  int n_fail   = 0;

  assign strb = {loadPC, PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite};

  multicycle_ctrl #(.RETIRE_W(32), .WAIT_ACK(1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .dAck(dAck),
    .loadPC(loadPC), .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .ALUCtrl(ALUCtrl), .MemRead(MemRead), .MemWrite(MemWrite),
    .state_o(state_o),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    n_checks++; if (strb !== 7'b0) begin n_fail++; $display("FAIL reset_strobes got=%b exp=0000000", strb); end
    n_checks++; if (ALUCtrl !== 4'b0010) begin n_fail++; $display("FAIL reset_aluctrl got=%b exp=0010", ALUCtrl); end
    n_checks++; if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    rst = 1'b1;
  endtask

  task automatic test_add();
    int lp;
    lp = 0;
    instr = 32'h002081B3;
    #1;
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL add_if_state got=%0d exp=0", state_o); end
    lp += int'(loadPC);
    step();
    n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL add_id_state got=%0d exp=1", state_o); end
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL add_id_regwrite got=%b exp=0", RegWrite); end
    lp += int'(loadPC);
    step();
    n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL add_ex_state got=%0d exp=2", state_o); end
    n_checks++; if (ALUCtrl !== 4'b0010) begin n_fail++; $display("FAIL add_ex_aluctrl got=%b exp=0010", ALUCtrl); end
    n_checks++; if (ALUSrc !== 1'b0) begin n_fail++; $display("FAIL add_ex_alusrc got=%b exp=0", ALUSrc); end
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL add_ex_regwrite got=%b exp=0", RegWrite); end
    lp += int'(loadPC);
    step();
    n_checks++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL add_wb_state got=%0d exp=4", state_o); end
    n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL add_wb_regwrite got=%b exp=1", RegWrite); end
    n_checks++; if (PCSrc !== 1'b0 || MemToReg !== 1'b0) begin n_fail++; $display("FAIL add_wb_pcsrc_memtoreg got=%b%b exp=00", PCSrc, MemToReg); end
    lp += int'(loadPC);
    step();
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL add_back_if got=%0d exp=0", state_o); end
    n_checks++; if (lp !== 1) begin n_fail++; $display("FAIL add_loadpc_count got=%0d exp=1", lp); end
    n_checks++; if (retired !== 32'd1) begin n_fail++; $display("FAIL add_retired got=%0d exp=1", retired); end
  endtask

  task automatic test_branch();
    // beq with Zero=1: taken
    instr = 32'h00208063;
    step();
    step();
    Zero = 1'b1;
    #1;
    n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL beq_ex_state got=%0d exp=2", state_o); end
    n_checks++; if (loadPC !== 1'b1 || PCSrc !== 1'b1) begin n_fail++; $display("FAIL beq_loadpc_pcsrc got=%b%b exp=11", loadPC, PCSrc); end
    n_checks++; if (RegWrite !== 1'b0 || ALUSrc !== 1'b0) begin n_fail++; $display("FAIL beq_regwrite_alusrc got=%b%b exp=00", RegWrite, ALUSrc); end
    n_checks++; if (ALUCtrl !== 4'b0110) begin n_fail++; $display("FAIL beq_aluctrl got=%b exp=0110", ALUCtrl); end
    step();
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL beq_3cyc got=%0d exp=0", state_o); end
    // bne with Zero=1: not taken
    instr = 32'h00209063;
    step();
    step();
    #1;
    n_checks++; if (loadPC !== 1'b1 || PCSrc !== 1'b0) begin n_fail++; $display("FAIL bne_z1_loadpc_pcsrc got=%b%b exp=10", loadPC, PCSrc); end
    Zero = 1'b0;
    #1;
    n_checks++; if (PCSrc !== 1'b1) begin n_fail++; $display("FAIL bne_z0_pcsrc got=%b exp=1", PCSrc); end
    step();
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL bne_3cyc got=%0d exp=0", state_o); end
    n_checks++; if (retired !== 32'd3) begin n_fail++; $display("FAIL branch_retired got=%0d exp=3", retired); end
  endtask

  task automatic test_lw_wait();
    int cyc;
    cyc = 0;
    instr = 32'h0000A183;
    dAck = 1'b0;
    step(); cyc++;
    step(); cyc++;
    n_checks++; if (ALUSrc !== 1'b1 || ALUCtrl !== 4'b0010) begin n_fail++; $display("FAIL lw_ex_alusrc_aluctrl got=%b_%b exp=1_0010", ALUSrc, ALUCtrl); end
    step(); cyc++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (state_o !== 3'd3 || MemRead !== 1'b1 || loadPC !== 1'b0 || ALUCtrl !== 4'b0010)
        begin n_fail++; $display("FAIL lw_mem_wait%0d st=%0d rd=%b lp=%b alu=%b exp=3,1,0,0010", i, state_o, MemRead, loadPC, ALUCtrl); end
      step(); cyc++;
    end
    dAck = 1'b1;
    #1;
    n_checks++; if (state_o !== 3'd3 || MemRead !== 1'b1 || MemWrite !== 1'b0 || loadPC !== 1'b0)
      begin n_fail++; $display("FAIL lw_mem_ack st=%0d rd=%b wr=%b lp=%b exp=3,1,0,0", state_o, MemRead, MemWrite, loadPC); end
    step(); cyc++;
    dAck = 1'b0;
    n_checks++; if (state_o !== 3'd4 || MemToReg !== 1'b1 || RegWrite !== 1'b1 || loadPC !== 1'b1 || ALUSrc !== 1'b1)
      begin n_fail++; $display("FAIL lw_wb st=%0d m2r=%b rw=%b lp=%b as=%b exp=4,1,1,1,1", state_o, MemToReg, RegWrite, loadPC, ALUSrc); end
    step(); cyc++;
    n_checks++; if (state_o !== 3'd0 || cyc !== 8) begin n_fail++; $display("FAIL lw_cycles st=%0d cyc=%0d exp=0,8", state_o, cyc); end
    n_checks++; if (retired !== 32'd4) begin n_fail++; $display("FAIL lw_retired got=%0d exp=4", retired); end
  endtask

  task automatic test_sw();
    instr = 32'h0030A023;
    step();
    step();
    dAck = 1'b1;
    step();
    n_checks++; if (state_o !== 3'd3 || MemWrite !== 1'b1 || loadPC !== 1'b1 || MemRead !== 1'b0)
      begin n_fail++; $display("FAIL sw_mem st=%0d wr=%b lp=%b rd=%b exp=3,1,1,0", state_o, MemWrite, loadPC, MemRead); end
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL sw_regwrite got=%b exp=0", RegWrite); end
    step();
    dAck = 1'b0;
    n_checks++; if (state_o !== 3'd0 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL sw_end st=%0d rw=%b exp=0,0", state_o, RegWrite); end
    n_checks++; if (retired !== 32'd5) begin n_fail++; $display("FAIL sw_retired got=%0d exp=5", retired); end
  endtask

  task automatic test_reset_mid();
    instr = 32'h0000A183;
    dAck = 1'b0;
    step();
    step();
    step();
    n_checks++; if (state_o !== 3'd3 || MemRead !== 1'b1) begin n_fail++; $display("FAIL rmid_in_mem st=%0d rd=%b exp=3,1", state_o, MemRead); end
    rst = 1'b0;
    step();
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL rmid_state got=%0d exp=0", state_o); end
    n_checks++; if (strb !== 7'b0) begin n_fail++; $display("FAIL rmid_strobes got=%b exp=0000000", strb); end
    n_checks++; if (retired !== 32'd0) begin n_fail++; $display("FAIL rmid_retired got=%0d exp=0", retired); end
    rst = 1'b1;
  endtask

  task automatic test_alu_decode();
    // sub (R, ir[30]=1) -> SUB
    instr = 32'h402081B3;
    step(); step();
    n_checks++; if (ALUCtrl !== 4'b0110 || ALUSrc !== 1'b0) begin n_fail++; $display("FAIL dec_sub got=%b_%b exp=0110_0", ALUCtrl, ALUSrc); end
    step(); step();
    // srai (I, funct3=101, ir[30]=1) -> SRA
    instr = 32'h4030D093;
    step(); step();
    n_checks++; if (ALUCtrl !== 4'b1010 || ALUSrc !== 1'b1) begin n_fail++; $display("FAIL dec_srai got=%b_%b exp=1010_1", ALUCtrl, ALUSrc); end
    step();
    n_checks++; if (ALUCtrl !== 4'b1010 || ALUSrc !== 1'b1) begin n_fail++; $display("FAIL dec_srai_wb got=%b_%b exp=1010_1", ALUCtrl, ALUSrc); end
    step();
    // addi with imm bit30 set -> still ADD
    instr = 32'hC0008093;
    step(); step();
    n_checks++; if (ALUCtrl !== 4'b0010) begin n_fail++; $display("FAIL dec_addi_neg got=%b exp=0010", ALUCtrl); end
    step(); step();
    n_checks++; if (retired !== 32'd3) begin n_fail++; $display("FAIL dec_retired got=%0d exp=3", retired); end
  endtask

  task automatic test_illegal();
    instr = 32'h0000007F;
    step();
    step();
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (state_o !== 3'd5 || illegal !== 1'b1 || strb !== 7'b0 || retired !== 32'd3)
        begin n_fail++; $display("FAIL ill_halt%0d st=%0d ill=%b strb=%b ret=%0d exp=5,1,0,3", i, state_o, illegal, strb, retired); end
      step();
    end
`else
    n_checks++; if (state_o !== 3'd2 || RegWrite !== 1'b0 || loadPC !== 1'b0)
      begin n_fail++; $display("FAIL ill_ex st=%0d rw=%b lp=%b exp=2,0,0", state_o, RegWrite, loadPC); end
    step();
    n_checks++; if (state_o !== 3'd4 || RegWrite !== 1'b0 || loadPC !== 1'b1 || PCSrc !== 1'b0)
      begin n_fail++; $display("FAIL ill_wb st=%0d rw=%b lp=%b pcs=%b exp=4,0,1,0", state_o, RegWrite, loadPC, PCSrc); end
    step();
    n_checks++; if (state_o !== 3'd0 || retired !== 32'd4) begin n_fail++; $display("FAIL ill_retired st=%0d ret=%0d exp=0,4", state_o, retired); end
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_add();
    test_branch();
    test_lw_wait();
    test_sw();
    test_reset_mid();
    test_alu_decode();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
